fifo_loop_ctrl: RTL and testbench

Sequencer that owns one FIFO instance and runs it as a recirculating buffer. It loads a batch of exactly FIFO_DEPTH words from an input stream, then rotates the batch through the FIFO NUM_LOOPS times. On each rotation it optionally increments every word (ADD_MODE). It then drains the batch to an output stream. It sits between the stream producer/consumer and the FIFO's push/pop/empty/full interface, and is instantiated beside the FIFO in a wrapper.

---
 rtl/fifo_loop_ctrl_pkg.sv | 18 +
 rtl/fifo_loop_ctrl_if.sv | 33 +++
 rtl/fifo.sv | 69 ++++++
 rtl/fifo_loop_top.sv | 61 ++++++
 rtl/fifo_loop_ctrl.sv | 141 ++++++++++++++
 tb/tb_fifo_loop_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fifo_loop_ctrl_pkg.sv
// Shared types and helpers for the recirculating FIFO sequencer.
// Holds the controller state encoding and the rotation counter sizing function.
// Imported by the controller, the wrapper and the bench.
package fifo_loop_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_LOOP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Enough bits to count every re-push of a batch, plus headroom for the terminal value.
  function automatic int rot_cnt_width(input int num_loops, input int depth);
    return $clog2(num_loops * depth + 1);
  endfunction

endpackage

// File: rtl/fifo_loop_ctrl_if.sv
// Input and output stream handshake bundle for the recirculating FIFO sequencer.
// Latency: none, wires only.
// Backpressure: valid/ready on both streams; master is the sequencer side.
interface fifo_loop_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Latency: a pushed word is visible on pop_data the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty.
module fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign pop_data = mem_q[rd_ptr_q];

  // Next pointers and occupancy from the guarded push/pop strobes.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? ptr_next(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_next(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Pointer and occupancy registers; a reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/fifo_loop_top.sv
// Pairs the recirculating sequencer with its FIFO, wired point to point.
// Latency: identical to fifo_loop_ctrl.
// Backpressure: stream handshakes pass straight through to the sequencer.
module fifo_loop_top
  import fifo_loop_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_WIDTH = 8,
  parameter int NUM_LOOPS  = 3,
  parameter int ADD_MODE   = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  fifo_loop_ctrl_if.master s
);

  logic                  push;
  logic [FIFO_WIDTH-1:0] push_data;
  logic                  pop;
  logic [FIFO_WIDTH-1:0] pop_data;
  logic                  empty;
  logic                  full;

  fifo_loop_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_WIDTH (FIFO_WIDTH),
    .NUM_LOOPS  (NUM_LOOPS),
    .ADD_MODE   (ADD_MODE)
  ) u_ctrl (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .s         (s),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .empty     (empty),
    .full      (full)
  );

  fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .empty     (empty),
    .full      (full)
  );

endmodule

// File: rtl/fifo_loop_ctrl.sv
// Loads one FIFO-sized batch, rotates it NUM_LOOPS times (optionally +1 per pass), then drains it.
// Latency: start to done is at least 2*FIFO_DEPTH + NUM_LOOPS*FIFO_DEPTH + 2 cycles.
// Backpressure: in_valid low stretches LOAD, out_ready low stalls DRAIN; LOOP runs free.
module fifo_loop_ctrl
  import fifo_loop_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_WIDTH = 8,
  parameter int NUM_LOOPS  = 3,
  parameter int ADD_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  fifo_loop_ctrl_if.master      s,
  output logic                  push,
  output logic [FIFO_WIDTH-1:0] push_data,
  output logic                  pop,
  input  logic [FIFO_WIDTH-1:0] pop_data,
  input  logic                  empty,
  input  logic                  full
);

  localparam int RW = rot_cnt_width(NUM_LOOPS, FIFO_DEPTH);
  localparam int DW = $clog2(FIFO_DEPTH + 1);
  localparam logic [RW-1:0] ROT_LAST   = RW'(NUM_LOOPS * FIFO_DEPTH - 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(FIFO_DEPTH);

  state_e                state_q, state_d;
  logic [FIFO_WIDTH-1:0] hold_q, hold_d;
  logic [RW-1:0]         rot_cnt_q, rot_cnt_d;
  logic                  first_q, first_d;
  logic [DW-1:0]         drn_cnt_q, drn_cnt_d;
  logic                  busy_q, busy_d;
  logic                  in_ready, out_valid;
  logic [FIFO_WIDTH-1:0] hold_f;

  // Word value re-pushed on each rotation.
  assign hold_f = (ADD_MODE != 0) ? hold_q + FIFO_WIDTH'(1) : hold_q;

  assign busy       = busy_q;
  assign s.in_ready  = in_ready;
  assign s.out_valid = out_valid;
  assign s.out_data  = pop_data;

  // Next-state, datapath and per-state handshake decode.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rot_cnt_d = rot_cnt_q;
    first_d   = first_q;
    drn_cnt_d = drn_cnt_q;
    push      = 1'b0;
    push_data = '0;
    pop       = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        in_ready  = !full;
        push      = s.in_valid && !full;
        push_data = s.in_data;
        // full is registered, so seeing it high means the last push already landed.
        if (full) begin
          state_d   = ST_LOOP;
          rot_cnt_d = '0;
          first_d   = 1'b1;
        end
      end

      ST_LOOP: begin
        if (first_q) begin
          // Prime the hold register; this leaves one free slot for the rest of the loop.
          pop     = 1'b1;
          hold_d  = pop_data;
          first_d = 1'b0;
        end else if (rot_cnt_q < ROT_LAST) begin
          pop       = 1'b1;
          push      = 1'b1;
          push_data = hold_f;
          hold_d    = pop_data;
          rot_cnt_d = rot_cnt_q + RW'(1);
        end else begin
          // Put the held word back; the FIFO is full again and in original order.
          push      = 1'b1;
          push_data = hold_f;
          state_d   = ST_DRAIN;
          drn_cnt_d = DRAIN_INIT;
        end
      end

      ST_DRAIN: begin
        out_valid = !empty;
        pop       = !empty && s.out_ready;
        if (!empty && s.out_ready) begin
          drn_cnt_d = drn_cnt_q - DW'(1);
          if (drn_cnt_q == DW'(1)) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, hold, counters and registered busy; reset abandons any batch in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      rot_cnt_q <= '0;
      first_q   <= 1'b0;
      drn_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rot_cnt_q <= rot_cnt_d;
      first_q   <= first_d;
      drn_cnt_q <= drn_cnt_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_loop_ctrl.sv
// Directed bench for the recirculating FIFO sequencer.
// Instance A: ADD_MODE=1 controller with a FIFO beside it; instance B: ADD_MODE=0 wrapper.
// Inputs change 1 time unit after the rising edge, outputs are sampled mid-cycle.
module tb_fifo_loop_ctrl;
  import fifo_loop_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start_a, busy_a, done_a;
  logic       push_a, pop_a, empty_a, full_a;
  logic [7:0] push_data_a, pop_data_a;
  logic       start_b, busy_b, done_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fifo_loop_ctrl_if #(.WIDTH(8)) ifa ();
  fifo_loop_ctrl_if #(.WIDTH(8)) ifb ();

  always #5 clk = ~clk;

  fifo_loop_ctrl #(
    .FIFO_DEPTH (4), .FIFO_WIDTH (8), .NUM_LOOPS (3), .ADD_MODE (1)
  ) u_dut (
    .clk (clk), .rstn (rstn), .start (start_a), .busy (busy_a), .done (done_a),
    .s (ifa.master), .push (push_a), .push_data (push_data_a), .pop (pop_a),
    .pop_data (pop_data_a), .empty (empty_a), .full (full_a)
  );

  fifo #(.DEPTH (4), .WIDTH (8)) u_fifo (
    .clk (clk), .rstn (rstn), .push (push_a), .push_data (push_data_a), .pop (pop_a),
    .pop_data (pop_data_a), .empty (empty_a), .full (full_a)
  );

  fifo_loop_top #(
    .FIFO_DEPTH (4), .FIFO_WIDTH (8), .NUM_LOOPS (3), .ADD_MODE (0)
  ) u_top (
    .clk (clk), .rstn (rstn), .start (start_b), .busy (busy_b), .done (done_b), .s (ifb.master)
  );

  // Mid-cycle monitors: outputs, done pulses, phase lengths and push-while-full events.
  int cyc = 0, done_cnt_a = 0, done_cnt_b = 0, last_done_a = 0, last_done_b = 0;
  int load_cyc_a = 0, load_push_a = 0, push_full_a = 0, loop_cyc_b = 0, push_full_b = 0;
  logic [7:0] out_q_a[$];
  logic [7:0] out_q_b[$];

  always @(negedge clk) begin
    if (done_a) begin done_cnt_a++; last_done_a = cyc; end
    if (done_b) begin done_cnt_b++; last_done_b = cyc; end
    if (ifa.out_valid && ifa.out_ready) out_q_a.push_back(ifa.out_data);
    if (ifb.out_valid && ifb.out_ready) out_q_b.push_back(ifb.out_data);
    if (u_dut.state_q == ST_LOAD) begin
      load_cyc_a++;
      if (push_a) load_push_a++;
    end
    if (push_a && full_a) push_full_a++;
    if (u_top.u_ctrl.state_q == ST_LOOP) loop_cyc_b++;
    if (u_top.push && u_top.full) push_full_b++;
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch(input bit sel_b, output int sc);
    sc = cyc;
    if (sel_b) start_b = 1'b1;
    else start_a = 1'b1;
    step;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic feed(input bit sel_b, input logic [7:0] w[4], input bit toggle, output bit ok);
    int  idx;
    int  n;
    bit  v;
    bit  acc;
    idx = 0; n = 0; v = 1'b1;
    while (idx < 4 && n < 100) begin
      if (sel_b) begin ifb.in_valid = v; ifb.in_data = w[idx]; end
      else begin ifa.in_valid = v; ifa.in_data = w[idx]; end
      #1;
      acc = sel_b ? (ifb.in_valid && ifb.in_ready) : (ifa.in_valid && ifa.in_ready);
      step;
      if (acc) idx++;
      if (toggle) v = !v;
      n++;
    end
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
    ok = (idx == 4);
  endtask

  task automatic wait_done(input bit sel_b, input int base, output bit ok);
    int n;
    n = 0;
    while ((sel_b ? done_cnt_b : done_cnt_a) == base && n < 300) begin
      step;
      n++;
    end
    ok = ((sel_b ? done_cnt_b : done_cnt_a) != base);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b1;
    step; step;
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else pass_cnt++;
    total_cnt++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b want 0", done_a); else pass_cnt++;
    total_cnt++; if (ifa.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", ifa.in_ready); else pass_cnt++;
    total_cnt++; if (ifa.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", ifa.out_valid); else pass_cnt++;
    total_cnt++; if (push_a !== 1'b0) $display("FAIL reset_push: got %b want 0", push_a); else pass_cnt++;
    total_cnt++; if (pop_a !== 1'b0) $display("FAIL reset_pop: got %b want 0", pop_a); else pass_cnt++;
    total_cnt++; if (push_data_a !== 8'h00) $display("FAIL reset_push_data: got %h want 00", push_data_a); else pass_cnt++;
    total_cnt++; if (busy_b !== 1'b0) $display("FAIL reset_busy_b: got %b want 0", busy_b); else pass_cnt++;
    rstn = 1'b1;
    step;
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL idle_after_reset: busy got %b want 0", busy_a); else pass_cnt++;
  endtask

  task automatic test_add_mode;
    logic [7:0] w[4];
    logic [7:0] e[4];
    int  sc, base, ob;
    bit  ok;
    w = '{8'h10, 8'h11, 8'h12, 8'hFE};
    e = '{8'h13, 8'h14, 8'h15, 8'h01};
    base = done_cnt_a; ob = out_q_a.size();
    start_batch(1'b0, sc);
    total_cnt++; if (busy_a !== 1'b1) $display("FAIL add_busy_after_start: got %b want 1", busy_a); else pass_cnt++;
    feed(1'b0, w, 1'b0, ok);
    total_cnt++; if (!ok) $display("FAIL add_feed: words not all accepted within budget"); else pass_cnt++;
    wait_done(1'b0, base, ok);
    total_cnt++; if (!ok) $display("FAIL add_done_timeout: no done within budget"); else pass_cnt++;
    total_cnt++; if (last_done_a - sc !== 22) $display("FAIL add_latency: got %0d cycles want 22", last_done_a - sc); else pass_cnt++;
    step; step;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (out_q_a.size() <= ob + i) $display("FAIL add_out%0d: missing word, want %h", i, e[i]);
      else if (out_q_a[ob + i] !== e[i]) $display("FAIL add_out%0d: got %h want %h", i, out_q_a[ob + i], e[i]);
      else pass_cnt++;
    end
    total_cnt++; if (done_cnt_a - base !== 1) $display("FAIL add_done_count: got %0d want 1", done_cnt_a - base); else pass_cnt++;
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL add_busy_after: got %b want 0", busy_a); else pass_cnt++;
  endtask

  task automatic test_pass_through;
    logic [7:0] w[4];
    int  sc, base, ob, lb, pf;
    bit  ok;
    w = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    base = done_cnt_b; ob = out_q_b.size(); lb = loop_cyc_b; pf = push_full_b;
    start_batch(1'b1, sc);
    feed(1'b1, w, 1'b0, ok);
    total_cnt++; if (!ok) $display("FAIL pass_feed: words not all accepted within budget"); else pass_cnt++;
    wait_done(1'b1, base, ok);
    total_cnt++; if (!ok) $display("FAIL pass_done_timeout: no done within budget"); else pass_cnt++;
    step;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (out_q_b.size() <= ob + i) $display("FAIL pass_out%0d: missing word, want %h", i, w[i]);
      else if (out_q_b[ob + i] !== w[i]) $display("FAIL pass_out%0d: got %h want %h", i, out_q_b[ob + i], w[i]);
      else pass_cnt++;
    end
    total_cnt++; if (loop_cyc_b - lb !== 13) $display("FAIL pass_loop_cycles: got %0d want 13", loop_cyc_b - lb); else pass_cnt++;
    total_cnt++; if (last_done_b - sc !== 22) $display("FAIL pass_latency: got %0d want 22", last_done_b - sc); else pass_cnt++;
    total_cnt++; if (push_full_b - pf !== 0) $display("FAIL pass_push_full: got %0d want 0", push_full_b - pf); else pass_cnt++;
  endtask

  task automatic test_valid_toggle;
    logic [7:0] w[4];
    logic [7:0] e[4];
    int  sc, base, ob, lc, lp, pf;
    bit  ok;
    w = '{8'h20, 8'h21, 8'h22, 8'h23};
    e = '{8'h23, 8'h24, 8'h25, 8'h26};
    base = done_cnt_a; ob = out_q_a.size(); lc = load_cyc_a; lp = load_push_a; pf = push_full_a;
    start_batch(1'b0, sc);
    feed(1'b0, w, 1'b1, ok);
    total_cnt++; if (!ok) $display("FAIL tog_feed: words not all accepted within budget"); else pass_cnt++;
    wait_done(1'b0, base, ok);
    total_cnt++; if (!ok) $display("FAIL tog_done_timeout: no done within budget"); else pass_cnt++;
    step;
    total_cnt++; if (load_push_a - lp !== 4) $display("FAIL tog_load_pushes: got %0d want 4", load_push_a - lp); else pass_cnt++;
    total_cnt++; if (load_cyc_a - lc !== 8) $display("FAIL tog_load_cycles: got %0d want 8", load_cyc_a - lc); else pass_cnt++;
    total_cnt++; if (push_full_a - pf !== 0) $display("FAIL tog_push_full: got %0d want 0", push_full_a - pf); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (out_q_a.size() <= ob + i) $display("FAIL tog_out%0d: missing word, want %h", i, e[i]);
      else if (out_q_a[ob + i] !== e[i]) $display("FAIL tog_out%0d: got %h want %h", i, out_q_a[ob + i], e[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_out_stall;
    logic [7:0] w[4];
    logic [7:0] e[4];
    int  sc, base, ob, n;
    bit  ok;
    w = '{8'h30, 8'h31, 8'h32, 8'h33};
    e = '{8'h33, 8'h34, 8'h35, 8'h36};
    base = done_cnt_a; ob = out_q_a.size();
    start_batch(1'b0, sc);
    feed(1'b0, w, 1'b0, ok);
    n = 0;
    while (out_q_a.size() < ob + 1 && n < 100) begin step; n++; end
    total_cnt++; if (out_q_a.size() < ob + 1) $display("FAIL stall_first_word: none within budget"); else pass_cnt++;
    ifa.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total_cnt++; if (ifa.out_valid !== 1'b1) $display("FAIL stall_valid c%0d: got %b want 1", c, ifa.out_valid); else pass_cnt++;
      total_cnt++; if (ifa.out_data !== 8'h34) $display("FAIL stall_data c%0d: got %h want 34", c, ifa.out_data); else pass_cnt++;
      total_cnt++; if (pop_a !== 1'b0) $display("FAIL stall_pop c%0d: got %b want 0", c, pop_a); else pass_cnt++;
      step;
    end
    ifa.out_ready = 1'b1;
    wait_done(1'b0, base, ok);
    total_cnt++; if (!ok) $display("FAIL stall_done_timeout: no done within budget"); else pass_cnt++;
    step;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (out_q_a.size() <= ob + i) $display("FAIL stall_out%0d: missing word, want %h", i, e[i]);
      else if (out_q_a[ob + i] !== e[i]) $display("FAIL stall_out%0d: got %h want %h", i, out_q_a[ob + i], e[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] w[4];
    logic [7:0] w2[4];
    logic [7:0] e[4];
    int  sc, base, ob, n;
    bit  ok;
    w  = '{8'h40, 8'h41, 8'h42, 8'h43};
    w2 = '{8'h50, 8'h51, 8'h52, 8'h53};
    e  = '{8'h53, 8'h54, 8'h55, 8'h56};
    start_batch(1'b0, sc);
    feed(1'b0, w, 1'b0, ok);
    n = 0;
    while (u_dut.state_q != ST_LOOP && n < 50) begin step; n++; end
    step; step; step;
    rstn = 1'b0;
    step;
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy_a); else pass_cnt++;
    total_cnt++; if (push_a !== 1'b0) $display("FAIL rmid_push: got %b want 0", push_a); else pass_cnt++;
    total_cnt++; if (pop_a !== 1'b0) $display("FAIL rmid_pop: got %b want 0", pop_a); else pass_cnt++;
    total_cnt++; if (empty_a !== 1'b1) $display("FAIL rmid_fifo_empty: got %b want 1", empty_a); else pass_cnt++;
    rstn = 1'b1;
    step;
    base = done_cnt_a; ob = out_q_a.size();
    start_batch(1'b0, sc);
    feed(1'b0, w2, 1'b0, ok);
    wait_done(1'b0, base, ok);
    total_cnt++; if (!ok) $display("FAIL rmid_done_timeout: no done within budget"); else pass_cnt++;
    step;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (out_q_a.size() <= ob + i) $display("FAIL rmid_out%0d: missing word, want %h", i, e[i]);
      else if (out_q_a[ob + i] !== e[i]) $display("FAIL rmid_out%0d: got %h want %h", i, out_q_a[ob + i], e[i]);
      else pass_cnt++;
    end
    total_cnt++; if (out_q_a.size() - ob !== 4) $display("FAIL rmid_word_count: got %0d want 4", out_q_a.size() - ob); else pass_cnt++;
  endtask

  task automatic test_start_ignored;
    logic [7:0] w[4];
    logic [7:0] w2[4];
    logic [7:0] e[8];
    int  sc, base, ob, n;
    bit  ok;
    w  = '{8'h60, 8'h61, 8'h62, 8'h63};
    w2 = '{8'h70, 8'h71, 8'h72, 8'h73};
    e  = '{8'h63, 8'h64, 8'h65, 8'h66, 8'h73, 8'h74, 8'h75, 8'h76};
    base = done_cnt_a; ob = out_q_a.size();
    start_batch(1'b0, sc);
    feed(1'b0, w, 1'b0, ok);
    n = 0;
    while (u_dut.state_q != ST_LOOP && n < 50) begin step; n++; end
    step; step;
    start_a = 1'b1;
    step;
    start_a = 1'b0;
    total_cnt++; if (u_dut.state_q !== ST_LOOP) $display("FAIL ign_loop_state: got %0d want %0d", u_dut.state_q, ST_LOOP); else pass_cnt++;
    n = 0;
    while (out_q_a.size() < ob + 3 && n < 300) begin step; n++; end
    start_a = 1'b1;
    #1;
    total_cnt++; if (done_a !== 1'b1) $display("FAIL ign_done_cycle: done got %b want 1", done_a); else pass_cnt++;
    step;
    start_a = 1'b0;
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL ign_start_in_done: busy got %b want 0", busy_a); else pass_cnt++;
    total_cnt++; if (done_cnt_a - base !== 1) $display("FAIL ign_done_count1: got %0d want 1", done_cnt_a - base); else pass_cnt++;
    start_batch(1'b0, sc);
    total_cnt++; if (busy_a !== 1'b1) $display("FAIL ign_restart: busy got %b want 1", busy_a); else pass_cnt++;
    feed(1'b0, w2, 1'b0, ok);
    wait_done(1'b0, base + 1, ok);
    total_cnt++; if (!ok) $display("FAIL ign_done_timeout: no done within budget"); else pass_cnt++;
    step; step;
    total_cnt++; if (done_cnt_a - base !== 2) $display("FAIL ign_done_count2: got %0d want 2", done_cnt_a - base); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (out_q_a.size() <= ob + i) $display("FAIL ign_out%0d: missing word, want %h", i, e[i]);
      else if (out_q_a[ob + i] !== e[i]) $display("FAIL ign_out%0d: got %h want %h", i, out_q_a[ob + i], e[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset;
    test_add_mode;
    test_pass_through;
    test_valid_toggle;
    test_out_stall;
    test_reset_mid;
    test_start_ignored;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
